// File: rtl/blackjack_pkg.sv
// Shared types and constants for the blackjack round controller.
// Holds the state encoding, the result codes and the hand-scoring helpers.
package blackjack_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DEAL_REQ,
    ST_DEAL_WAIT,
    ST_PLAYER,
    ST_HIT_REQ,
    ST_HIT_WAIT,
    ST_DEALER_REQ,
    ST_DEALER_WAIT,
    ST_RESULT
  } state_t;

  typedef enum logic [1:0] {
    RES_NONE = 2'b00,
    RES_PWIN = 2'b01,
    RES_DWIN = 2'b10,
    RES_PUSH = 2'b11
  } result_t;

  localparam logic [4:0] BJ_TOTAL     = 5'd21;
  localparam logic [4:0] DEALER_STAND = 5'd17;
  localparam logic [4:0] ACE_BONUS    = 5'd10;
  localparam logic [4:0] SOFT_LIMIT   = BJ_TOTAL - ACE_BONUS;
  localparam logic [4:0] SUM_MAX      = 5'd31;
  localparam logic [3:0] CARD_MAX     = 4'd10;

  function automatic logic card_ok(input logic [3:0] card);
    return (card != 4'd0) && (card <= CARD_MAX);
  endfunction

  // One ace may count as 11 only while that cannot push the hand over 21.
  function automatic logic [4:0] best_total(input logic [4:0] hard, input logic ace);
    return (ace && (hard <= SOFT_LIMIT)) ? hard + ACE_BONUS : hard;
  endfunction

  function automatic result_t compare_hands(input logic [4:0] p_best, input logic [4:0] d_best);
    if (p_best > BJ_TOTAL)      return RES_DWIN;
    else if (d_best > BJ_TOTAL) return RES_PWIN;
    else if (p_best > d_best)   return RES_PWIN;
    else if (p_best < d_best)   return RES_DWIN;
    else                        return RES_PUSH;
  endfunction

endpackage

// File: rtl/blackjack_round_ctrl_hand_accum.sv
// One hand: saturating hard sum plus ace flag, with the current best total
// and the best total the hand would have after adding the cards on its inputs.
module hand_accum
  import blackjack_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_clear,
  input  logic       i_add,
  input  logic [3:0] i_card_a,
  input  logic [3:0] i_card_b,
  output logic [4:0] o_best,
  output logic [4:0] o_next_best
);

  logic [4:0] r_hard;
  logic       r_ace;
  logic [5:0] w_raw;
  logic [4:0] w_next_hard;
  logic       w_next_ace;

  assign w_raw       = {1'b0, r_hard} + {2'b00, i_card_a} + {2'b00, i_card_b};
  assign w_next_hard = (w_raw > {1'b0, SUM_MAX}) ? SUM_MAX : w_raw[4:0];
  assign w_next_ace  = r_ace | (i_card_a == 4'd1) | (i_card_b == 4'd1);

  // NOTE: non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hard <= 5'd0;
      r_ace  <= 1'b0;
    end else if (i_clear) begin
      r_hard <= 5'd0;
      r_ace  <= 1'b0;
    end else if (i_add) begin
      r_hard <= w_next_hard;
      r_ace  <= w_next_ace;
    end
  end

  assign o_best      = best_total(r_hard, r_ace);
  assign o_next_best = best_total(w_next_hard, w_next_ace);

endmodule

// File: rtl/blackjack_round_ctrl.sv
// Blackjack round sequencer: deal, player turn, dealer turn, settle.
// Cards arrive one cycle after card_on; invalid cards are re-requested.
module blackjack_round_ctrl
  import blackjack_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       hit,
  input  logic       stand,
  input  logic       dbl,
  input  logic [3:0] card1_in,
  input  logic [3:0] card2_in,
  input  logic [3:0] card3_in,
  input  logic [3:0] card4_in,
  output logic       card_on,
  output logic [4:0] player_sum,
  output logic [4:0] dealer_sum,
  output logic       busy,
  output logic       done,
  output logic [1:0] result,
  output logic       doubled,
  output logic       player_bj
);

  state_t     r_state;
  state_t     w_next;
  logic       r_hit_q, r_stand_q, r_dbl_q;
  logic       r_done, r_doubled, r_player_bj;
  logic [1:0] r_player_cards;

  logic       w_hit_rise, w_stand_rise, w_dbl_rise;
  logic       w_clear, w_deal_ok, w_hit_ok, w_dealer_ok;
  logic       w_p_add, w_d_add;
  logic [3:0] w_p_card_b, w_d_card_b;
  logic [4:0] w_p_best, w_p_next, w_d_best, w_d_next;
  logic       w_two_cards, w_dealer_draws;
  logic       w_set_doubled, w_set_bj;

  assign w_hit_rise   = hit & ~r_hit_q;
  assign w_stand_rise = stand & ~r_stand_q;
  assign w_dbl_rise   = dbl & ~r_dbl_q;

  assign w_clear     = ((r_state == ST_IDLE) || (r_state == ST_RESULT)) && start;
  assign w_deal_ok   = card_ok(card1_in) && card_ok(card2_in) && card_ok(card3_in) && card_ok(card4_in);
  assign w_hit_ok    = card_ok(card1_in);
  assign w_dealer_ok = card_ok(card3_in);

  assign w_p_add    = ((r_state == ST_DEAL_WAIT) && w_deal_ok) || ((r_state == ST_HIT_WAIT) && w_hit_ok);
  assign w_d_add    = ((r_state == ST_DEAL_WAIT) && w_deal_ok) || ((r_state == ST_DEALER_WAIT) && w_dealer_ok);
  assign w_p_card_b = (r_state == ST_DEAL_WAIT) ? card2_in : 4'd0;
  assign w_d_card_b = (r_state == ST_DEAL_WAIT) ? card4_in : 4'd0;

  hand_accum u_player (
    .clk        (clk),
    .reset      (reset),
    .i_clear    (w_clear),
    .i_add      (w_p_add),
    .i_card_a   (card1_in),
    .i_card_b   (w_p_card_b),
    .o_best     (w_p_best),
    .o_next_best(w_p_next)
  );

  hand_accum u_dealer (
    .clk        (clk),
    .reset      (reset),
    .i_clear    (w_clear),
    .i_add      (w_d_add),
    .i_card_a   (card3_in),
    .i_card_b   (w_d_card_b),
    .o_best     (w_d_best),
    .o_next_best(w_d_next)
  );

  assign w_two_cards    = (r_player_cards == 2'd2);
  assign w_dealer_draws = (w_d_best < DEALER_STAND);

  // NOTE: every always_comb output gets a default first, so no path infers a latch.
  always_comb begin
    w_next        = r_state;
    w_set_doubled = 1'b0;
    w_set_bj      = 1'b0;
    case (r_state)
      ST_IDLE:        if (start) w_next = ST_DEAL_REQ;
      ST_DEAL_REQ:    w_next = ST_DEAL_WAIT;
      ST_DEAL_WAIT:   w_next = w_deal_ok ? ST_PLAYER : ST_DEAL_REQ;
      ST_PLAYER: begin
        if (w_two_cards && (w_p_best == BJ_TOTAL)) begin
          w_set_bj = 1'b1;
          w_next   = ST_RESULT;
        end else if (w_stand_rise) begin
          w_next = w_dealer_draws ? ST_DEALER_REQ : ST_RESULT;
        end else if (w_dbl_rise && w_two_cards) begin
          w_set_doubled = 1'b1;
          w_next        = ST_HIT_REQ;
        end else if (w_hit_rise) begin
          w_next = ST_HIT_REQ;
        end
      end
      ST_HIT_REQ:     w_next = ST_HIT_WAIT;
      ST_HIT_WAIT: begin
        // Decisions use the post-capture total so bust and 21 are acted on at once.
        if (!w_hit_ok)                              w_next = ST_HIT_REQ;
        else if (w_p_next > BJ_TOTAL)               w_next = ST_RESULT;
        else if ((w_p_next == BJ_TOTAL) || r_doubled) w_next = w_dealer_draws ? ST_DEALER_REQ : ST_RESULT;
        else                                        w_next = ST_PLAYER;
      end
      ST_DEALER_REQ:  w_next = ST_DEALER_WAIT;
      ST_DEALER_WAIT: begin
        if (!w_dealer_ok || (w_d_next < DEALER_STAND)) w_next = ST_DEALER_REQ;
        else                                           w_next = ST_RESULT;
      end
      ST_RESULT:      if (start) w_next = ST_DEAL_REQ;
      default:        w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_hit_q        <= 1'b0;
      r_stand_q      <= 1'b0;
      r_dbl_q        <= 1'b0;
      r_done         <= 1'b0;
      r_doubled      <= 1'b0;
      r_player_bj    <= 1'b0;
      r_player_cards <= 2'd0;
    end else begin
      r_state   <= w_next;
      r_hit_q   <= hit;
      r_stand_q <= stand;
      r_dbl_q   <= dbl;
      r_done    <= (w_next == ST_RESULT) && (r_state != ST_RESULT);
      if (w_clear) begin
        r_doubled      <= 1'b0;
        r_player_bj    <= 1'b0;
        r_player_cards <= 2'd0;
      end else begin
        if (w_set_doubled) r_doubled   <= 1'b1;
        if (w_set_bj)      r_player_bj <= 1'b1;
        if ((r_state == ST_DEAL_WAIT) && w_deal_ok)
          r_player_cards <= 2'd2;
        else if ((r_state == ST_HIT_WAIT) && w_hit_ok && (r_player_cards != 2'd3))
          r_player_cards <= r_player_cards + 2'd1;
      end
    end
  end

  assign card_on    = (r_state == ST_DEAL_REQ) || (r_state == ST_HIT_REQ) || (r_state == ST_DEALER_REQ);
  assign busy       = (r_state != ST_IDLE);
  assign done       = r_done;
  assign result     = (r_state == ST_RESULT) ? compare_hands(w_p_best, w_d_best) : RES_NONE;
  assign player_sum = w_p_best;
  assign dealer_sum = w_d_best;
  assign doubled    = r_doubled;
  assign player_bj  = r_player_bj;

endmodule

// File: tb/tb_blackjack_round_ctrl.sv
// Directed bench for blackjack_round_ctrl: a table of whole rounds with
// hand-computed results, plus a mid-round reset sequence.
module tb_blackjack_round_ctrl;

  logic       clk = 1'b0;
  logic       reset, start, hit, stand, dbl;
  logic [3:0] card1_in, card2_in, card3_in, card4_in;
  logic       card_on, busy, done, doubled, player_bj;
  logic [4:0] player_sum, dealer_sum;
  logic [1:0] result;

  always #5 clk = ~clk;

  blackjack_round_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .hit       (hit),
    .stand     (stand),
    .dbl       (dbl),
    .card1_in  (card1_in),
    .card2_in  (card2_in),
    .card3_in  (card3_in),
    .card4_in  (card4_in),
    .card_on   (card_on),
    .player_sum(player_sum),
    .dealer_sum(dealer_sum),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .doubled   (doubled),
    .player_bj (player_bj)
  );

  typedef enum int {A_STAND, A_DBL, A_NONE, A_HIT, A_HS, A_HOLD, A_HDS} act_e;

  // src: up to four card-source answers {card1,card2,card3,card4}, first at the top.
  typedef struct {
    logic [63:0] src;
    int          n_src;
    act_e        act;
    int          ps;
    int          ds;
    int          res;
    int          dbl_f;
    int          bj;
    int          pulses;
    int          lat;
  } vec_t;

  localparam int NVEC = 13;
  vec_t vecs [NVEC];

  logic [15:0] card_q [$];
  int n_checks = 0;
  int n_err    = 0;
  int cyc_cnt  = 0;
  int card_pulses = 0;
  int done_cnt  = 0;
  int done_cyc  = 0;
  int done_long = 0;
  logic done_prev = 1'b0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Card source with one cycle of latency, plus a done-pulse monitor.
  initial begin
    logic [15:0] ent;
    forever begin
      @(negedge clk);
      if (card_on === 1'b1) begin
        card_pulses++;
        ent = (card_q.size() > 0) ? card_q.pop_front() : 16'h0000;
        {card1_in, card2_in, card3_in, card4_in} = ent;
      end
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc_cnt;
        if (done_prev) done_long++;
      end
      done_prev = (done === 1'b1);
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive_act(input logic h, input logic s, input logic d);
    hit = h; stand = s; dbl = d;
    @(negedge clk);
    hit = 1'b0; stand = 1'b0; dbl = 1'b0;
  endtask

  task automatic wait_player(input string tag);
    bit ok = 0;
    for (int k = 0; k < 60; k++) begin
      if (player_sum !== 5'd0) begin ok = 1; break; end
      @(negedge clk);
    end
    check({tag, "_deal_seen"}, 32'(ok), 1);
  endtask

  task automatic run_round(input int idx);
    vec_t  v;
    int    d0, p0, t0;
    bit    ok;
    string tag;
    v   = vecs[idx];
    tag = $sformatf("v%0d", idx);
    card_q.delete();
    for (int k = 0; k < v.n_src; k++) card_q.push_back(v.src[63-16*k -: 16]);
    d0 = done_cnt;
    p0 = card_pulses;
    start = 1'b1;
    t0 = cyc_cnt;
    @(negedge clk);
    start = 1'b0;
    wait_player(tag);
    case (v.act)
      A_STAND: drive_act(0, 1, 0);
      A_DBL:   drive_act(0, 0, 1);
      A_HIT: begin
        drive_act(1, 0, 0);
        repeat (3) @(negedge clk);
        if (done_cnt == d0) drive_act(0, 1, 0);
      end
      A_HS:    drive_act(1, 1, 0);
      A_HOLD: begin
        hit = 1'b1;
        repeat (8) @(negedge clk);
        hit = 1'b0;
        @(negedge clk);
        drive_act(0, 1, 0);
      end
      A_HDS: begin
        drive_act(1, 0, 0);
        repeat (3) @(negedge clk);
        drive_act(0, 0, 1);
        @(negedge clk);
        drive_act(0, 1, 0);
      end
      default: ;
    endcase
    ok = 0;
    for (int k = 0; k < 300; k++) begin
      if (done_cnt != d0) begin ok = 1; break; end
      @(negedge clk);
    end
    check({tag, "_done_seen"}, 32'(ok), 1);
    check({tag, "_player_sum"}, 32'(player_sum), v.ps);
    check({tag, "_dealer_sum"}, 32'(dealer_sum), v.ds);
    check({tag, "_result"}, 32'(result), v.res);
    check({tag, "_doubled"}, 32'(doubled), v.dbl_f);
    check({tag, "_player_bj"}, 32'(player_bj), v.bj);
    if (v.lat != 0) check({tag, "_done_latency"}, 32'(done_cyc - t0), v.lat);
    repeat (3) @(negedge clk);
    check({tag, "_hold_result"}, 32'(result), v.res);
    check({tag, "_hold_psum"}, 32'(player_sum), v.ps);
    check({tag, "_hold_dsum"}, 32'(dealer_sum), v.ds);
    check({tag, "_hold_busy"}, 32'(busy), 1);
    check({tag, "_card_pulses"}, 32'(card_pulses - p0), v.pulses);
    check({tag, "_done_pulses"}, 32'(done_cnt - d0), 1);
    check({tag, "_done_width"}, 32'(done_long), 0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_card_on"}, 32'(card_on), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_result"}, 32'(result), 0);
    check({tag, "_player_sum"}, 32'(player_sum), 0);
    check({tag, "_dealer_sum"}, 32'(dealer_sum), 0);
    check({tag, "_doubled"}, 32'(doubled), 0);
    check({tag, "_player_bj"}, 32'(player_bj), 0);
  endtask

  initial begin
    int  d0;
    bit  seen;
    vecs[0]  = '{64'hA857_0060_0000_0000, 2, A_STAND, 18, 18, 3, 0, 0, 2, 0};
    vecs[1]  = '{64'hA857_2000_0060_0000, 3, A_DBL,   20, 18, 1, 1, 0, 3, 0};
    vecs[2]  = '{64'hA1A1_0000_0000_0000, 1, A_NONE,  21, 21, 3, 0, 1, 1, 4};
    vecs[3]  = '{64'hA8A9_4000_0000_0000, 2, A_HIT,   22, 19, 2, 0, 0, 2, 0};
    vecs[4]  = '{64'hA716_0000_0000_0000, 1, A_STAND, 17, 17, 3, 0, 0, 1, 0};
    vecs[5]  = '{64'hA9A6_00A0_0000_0000, 2, A_STAND, 19, 26, 1, 0, 0, 2, 0};
    vecs[6]  = '{64'h15AA_A000_0000_0000, 2, A_HIT,   16, 20, 2, 0, 0, 2, 0};
    vecs[7]  = '{64'h56A7_A000_0000_0000, 2, A_HIT,   21, 17, 1, 0, 0, 2, 0};
    vecs[8]  = '{64'h9915_0010_0000_0000, 2, A_STAND, 18, 17, 1, 0, 0, 2, 0};
    vecs[9]  = '{64'hA257_A000_0000_0000, 2, A_DBL,   22, 12, 2, 1, 0, 2, 0};
    vecs[10] = '{64'hA057_A857_0060_0000, 3, A_HS,    18, 18, 3, 0, 0, 3, 0};
    vecs[11] = '{64'h23A7_2000_0000_0000, 2, A_HOLD,   7, 17, 2, 0, 0, 2, 0};
    vecs[12] = '{64'h23A7_2000_0000_0000, 2, A_HDS,    7, 17, 2, 0, 0, 2, 0};

    reset = 1'b1; start = 1'b0; hit = 1'b0; stand = 1'b0; dbl = 1'b0;
    {card1_in, card2_in, card3_in, card4_in} = 16'h0000;
    #12;
    check_reset_values("reset");
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_busy_without_start", 32'(busy), 0);

    for (int i = 0; i < NVEC; i++) run_round(i);

    // Abort a round with reset while the dealer's card is outstanding.
    card_q.delete();
    card_q.push_back(16'hA857);
    card_q.push_back(16'h0060);
    d0 = done_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_player("rst");
    drive_act(0, 1, 0);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      if (card_on === 1'b1) begin seen = 1; break; end
      @(negedge clk);
    end
    check("rst_dealer_req_seen", 32'(seen), 1);
    @(negedge clk);
    check("rst_busy_before", 32'(busy), 1);
    reset = 1'b1;
    #1;
    check_reset_values("rst_mid");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_no_done", 32'(done_cnt - d0), 0);
    check("rst_idle_busy", 32'(busy), 0);
    run_round(0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
